// File: rtl/ntt_pkg.sv
// Shared NTT definitions: controller FSM states, stage-index width, and butterfly span helper.
package ntt_pkg;

    localparam int unsigned STAGE_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StFinish
    } ntt_state_e;

    // log2 of the DIF half-span h = N >> (stage+1)
    function automatic int unsigned half_span_log2(input int unsigned log_n,
                                                   input int unsigned stage);
        return log_n - 1 - stage;
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register with synchronous clear; aligns issued reads with write-back.
module ntt_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_controller.sv
// Address/twiddle sequencer for an in-place radix-2 DIF NTT; one butterfly pair per issue cycle.
module ntt_stage_controller
    import ntt_pkg::*;
#(
    parameter int unsigned  LOG_N  = 8,
    parameter int unsigned  BF_LAT = 2,
    localparam int unsigned TW_W   = (LOG_N > 1) ? LOG_N - 1 : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [STAGE_W-1:0] stage,
    output logic               rd_en,
    output logic [LOG_N-1:0]   rd_addr_a,
    output logic [LOG_N-1:0]   rd_addr_b,
    output logic [TW_W-1:0]    tw_idx,
    output logic               wr_en,
    output logic [LOG_N-1:0]   wr_addr_a,
    output logic [LOG_N-1:0]   wr_addr_b
);

    localparam int unsigned HALF_N  = 2 ** (LOG_N - 1);
    localparam int unsigned DRAIN_W = $clog2(BF_LAT + 1);
    localparam int unsigned DL_W    = 2 * LOG_N + 1;

    ntt_state_e         state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [LOG_N-1:0]   pair_q, pair_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               pair_last, drain_last, stage_last;

    int unsigned        span_log2, pair_ext, k_off, addr_a;
    logic [LOG_N-1:0]   issue_a, issue_b;
    logic [TW_W-1:0]    issue_tw;

    assign pair_last  = (32'(pair_q) == HALF_N - 1);
    assign drain_last = (32'(drain_q) == BF_LAT - 1);
    assign stage_last = (32'(stage_q) == LOG_N - 1);

    // Pair p splits into group g = p >> log2(h) and offset k = p mod h.
    always_comb begin
        span_log2 = half_span_log2(LOG_N, 32'(stage_q));
        pair_ext  = 32'(pair_q);
        k_off     = pair_ext & ((32'd1 << span_log2) - 32'd1);
        addr_a    = ((pair_ext >> span_log2) << (span_log2 + 1)) | k_off;
        issue_a   = LOG_N'(addr_a);
        issue_b   = LOG_N'(addr_a + (32'd1 << span_log2));
        issue_tw  = TW_W'(k_off << stage_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            stage_q <= '0;
            pair_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            pair_q  <= pair_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        pair_d  = pair_q;
        drain_d = drain_q;
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    stage_d = '0;
                    pair_d  = '0;
                end
            end
            StIssue: begin
                busy   = 1'b1;
                rd_en  = 1'b1;
                pair_d = pair_q + 1'b1;
                if (pair_last) begin
                    state_d = StDrain;
                    pair_d  = '0;
                    drain_d = '0;
                end
            end
            StDrain: begin
                busy    = 1'b1;
                drain_d = drain_q + 1'b1;
                if (drain_last) begin
                    if (stage_last) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StIssue;
                        stage_d = stage_q + 1'b1;
                    end
                end
            end
            StFinish: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Gate everything so idle and post-reset outputs are all zero.
    assign stage     = busy  ? stage_q  : '0;
    assign rd_addr_a = rd_en ? issue_a  : '0;
    assign rd_addr_b = rd_en ? issue_b  : '0;
    assign tw_idx    = rd_en ? issue_tw : '0;

    ntt_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (BF_LAT)
    ) u_wr_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({rd_en, rd_addr_a, rd_addr_b}),
        .dout ({wr_en, wr_addr_a, wr_addr_b})
    );

endmodule

// File: tb/tb_ntt_stage_controller.sv
// Self-checking bench: three controller configurations checked against a closed-form schedule model.
module tb_ntt_stage_controller;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [3:0]  stage;
        logic        rd_en;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] tw;
        logic        wr_en;
        logic [15:0] wa;
        logic [15:0] wb;
    } obs_t;

    typedef struct packed {
        logic        en;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] tw;
    } pair_t;

    typedef struct {
        int cyc;
        int is_wr;
        int a;
        int b;
        int tw;
    } vec_t;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // LOG_N=3, BF_LAT=2
    logic       rst3, start3, busy3, done3, rd_en3, wr_en3;
    logic [3:0] stage3;
    logic [2:0] ra3, rb3, wa3, wb3;
    logic [1:0] tw3;
    // LOG_N=1, BF_LAT=1
    logic       rst1, start1, busy1, done1, rd_en1, wr_en1;
    logic [3:0] stage1;
    logic [0:0] ra1, rb1, wa1, wb1, tw1;
    // LOG_N=8, BF_LAT=3
    logic       rst8, start8, busy8, done8, rd_en8, wr_en8;
    logic [3:0] stage8;
    logic [7:0] ra8, rb8, wa8, wb8;
    logic [6:0] tw8;

    obs_t obs3, obs1, obs8;
    obs_t log3 [64];
    obs_t log1 [8];
    vec_t tbl [16];
    int   seen [8][256];

    ntt_stage_controller #(.LOG_N(3), .BF_LAT(2)) u_dut3 (
        .clk(clk), .rst(rst3), .start(start3), .busy(busy3), .done(done3), .stage(stage3),
        .rd_en(rd_en3), .rd_addr_a(ra3), .rd_addr_b(rb3), .tw_idx(tw3),
        .wr_en(wr_en3), .wr_addr_a(wa3), .wr_addr_b(wb3)
    );

    ntt_stage_controller #(.LOG_N(1), .BF_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1), .stage(stage1),
        .rd_en(rd_en1), .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_idx(tw1),
        .wr_en(wr_en1), .wr_addr_a(wa1), .wr_addr_b(wb1)
    );

    ntt_stage_controller #(.LOG_N(8), .BF_LAT(3)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .busy(busy8), .done(done8), .stage(stage8),
        .rd_en(rd_en8), .rd_addr_a(ra8), .rd_addr_b(rb8), .tw_idx(tw8),
        .wr_en(wr_en8), .wr_addr_a(wa8), .wr_addr_b(wb8)
    );

    always_comb begin
        obs3 = '0;
        obs3.busy = busy3; obs3.done = done3; obs3.stage = stage3; obs3.rd_en = rd_en3;
        obs3.ra = 16'(ra3); obs3.rb = 16'(rb3); obs3.tw = 16'(tw3);
        obs3.wr_en = wr_en3; obs3.wa = 16'(wa3); obs3.wb = 16'(wb3);
    end

    always_comb begin
        obs1 = '0;
        obs1.busy = busy1; obs1.done = done1; obs1.stage = stage1; obs1.rd_en = rd_en1;
        obs1.ra = 16'(ra1); obs1.rb = 16'(rb1); obs1.tw = 16'(tw1);
        obs1.wr_en = wr_en1; obs1.wa = 16'(wa1); obs1.wb = 16'(wb1);
    end

    always_comb begin
        obs8 = '0;
        obs8.busy = busy8; obs8.done = done8; obs8.stage = stage8; obs8.rd_en = rd_en8;
        obs8.ra = 16'(ra8); obs8.rb = 16'(rb8); obs8.tw = 16'(tw8);
        obs8.wr_en = wr_en8; obs8.wa = 16'(wa8); obs8.wb = 16'(wb8);
    end

    // Pair issued r cycles after start is sampled (r=0 is the start cycle).
    function automatic pair_t issued(int log_n, int bf, int r);
        pair_t o    = '0;
        int    half = (1 << log_n) / 2;
        int    per  = half + bf;
        int    t    = log_n * per;
        if (r >= 1 && r <= t) begin
            int q = (r - 1) % per;
            int s = (r - 1) / per;
            if (q < half) begin
                int h = (1 << log_n) >> (s + 1);
                int k = q % h;
                int g = q / h;
                int a = g * 2 * h + k;
                o.en = 1'b1;
                o.a  = 16'(a);
                o.b  = 16'(a + h);
                o.tw = 16'(k * (1 << s));
            end
        end
        return o;
    endfunction

    function automatic obs_t model(int log_n, int bf, int r);
        obs_t  o   = '0;
        pair_t rd;
        pair_t wr;
        int    per = (1 << log_n) / 2 + bf;
        int    t   = log_n * per;
        rd = issued(log_n, bf, r);
        wr = issued(log_n, bf, r - bf);
        if (r >= 1 && r <= t) begin
            o.busy  = 1'b1;
            o.stage = 4'((r - 1) / per);
        end
        o.done  = (r == t + 1);
        o.rd_en = rd.en; o.ra = rd.a; o.rb = rd.b; o.tw = rd.tw;
        o.wr_en = wr.en; o.wa = wr.a; o.wb = wr.b;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("busy=%0b done=%0b stage=%0d rd=%0b(%0d,%0d) tw=%0d wr=%0b(%0d,%0d)",
                         o.busy, o.done, o.stage, o.rd_en, o.ra, o.rb, o.tw,
                         o.wr_en, o.wa, o.wb);
    endfunction

    task automatic check_obs(string name, int cyc, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %s need %s", name, cyc, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_val(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d need %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int    hazards;
        int    rs;
        int    gap, lat, wcount, bad;
        pair_t got, want;

        tbl[0]  = '{1, 0, 0, 4, 0};  tbl[1]  = '{2, 0, 1, 5, 1};
        tbl[2]  = '{3, 0, 2, 6, 2};  tbl[3]  = '{4, 0, 3, 7, 3};
        tbl[4]  = '{7, 0, 0, 2, 0};  tbl[5]  = '{8, 0, 1, 3, 2};
        tbl[6]  = '{9, 0, 4, 6, 0};  tbl[7]  = '{10, 0, 5, 7, 2};
        tbl[8]  = '{13, 0, 0, 1, 0}; tbl[9]  = '{14, 0, 2, 3, 0};
        tbl[10] = '{15, 0, 4, 5, 0}; tbl[11] = '{16, 0, 6, 7, 0};
        tbl[12] = '{3, 1, 0, 4, 0};  tbl[13] = '{4, 1, 1, 5, 0};
        tbl[14] = '{5, 1, 2, 6, 0};  tbl[15] = '{6, 1, 3, 7, 0};

        start3 = 1'b0; start1 = 1'b0; start8 = 1'b0;
        rst3 = 1'b1; rst1 = 1'b1; rst8 = 1'b1;
        tick();
        tick();
        check_obs("reset3", 0, obs3, '0);
        check_obs("reset1", 0, obs1, '0);
        check_obs("reset8", 0, obs8, '0);
        rst3 = 1'b0; rst1 = 1'b0; rst8 = 1'b0;

        // N=8 run with ignored starts at 5 and 19, restart at 20
        hazards = 0;
        for (int c = 0; c < 46; c++) begin
            rs = (c >= 20) ? 20 : 0;
            log3[c] = obs3;
            check_obs("n8_run", c, obs3, model(3, 2, c - rs));
            if (obs3.rd_en && obs3.wr_en &&
                (obs3.ra == obs3.wa || obs3.ra == obs3.wb ||
                 obs3.rb == obs3.wa || obs3.rb == obs3.wb)) begin
                hazards++;
            end
            start3 = (c == 0 || c == 5 || c == 19 || c == 20);
            tick();
        end
        start3 = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].is_wr != 0) begin
                got  = {log3[tbl[i].cyc].wr_en, log3[tbl[i].cyc].wa, log3[tbl[i].cyc].wb, 16'd0};
                want = {1'b1, 16'(tbl[i].a), 16'(tbl[i].b), 16'd0};
            end else begin
                got  = {log3[tbl[i].cyc].rd_en, log3[tbl[i].cyc].ra, log3[tbl[i].cyc].rb,
                        log3[tbl[i].cyc].tw};
                want = {1'b1, 16'(tbl[i].a), 16'(tbl[i].b), 16'(tbl[i].tw)};
            end
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL vec%0d cyc %0d: got en=%0b (%0d,%0d) tw=%0d need (%0d,%0d) tw=%0d",
                         i, tbl[i].cyc, got.en, got.a, got.b, got.tw, want.a, want.b, want.tw);
            end
        end
        check_val("done_c19", int'(log3[19].done), 1);
        check_val("busy_c18", int'(log3[18].busy), 1);
        check_val("busy_c19", int'(log3[19].busy), 0);
        check_val("rd_c20", int'(log3[20].rd_en), 0);
        check_val("rd_c21", int'(log3[21].rd_en), 1);
        check_val("raw_hazard", hazards, 0);

        // Reset mid-run at cycle 8, then a clean restart at 21
        for (int c = 0; c <= 32; c++) begin
            if (c <= 8) begin
                check_obs("pre_rst", c, obs3, model(3, 2, c));
            end else if (c <= 20) begin
                check_obs("rst_quiet", c, obs3, '0);
            end else begin
                check_obs("post_rst", c, obs3, model(3, 2, c - 21));
            end
            start3 = (c == 0 || c == 21);
            rst3   = (c == 8);
            tick();
        end
        start3 = 1'b0;
        rst3   = 1'b0;

        // N=2 single butterfly
        for (int c = 0; c < 8; c++) begin
            log1[c] = obs1;
            check_obs("n2_run", c, obs1, model(1, 1, c));
            start1 = (c == 0);
            tick();
        end
        start1 = 1'b0;
        check_val("n2_rd_c1", int'({log1[1].rd_en, log1[1].ra[0], log1[1].rb[0]}), 3'b101);
        check_val("n2_wr_c2", int'({log1[2].wr_en, log1[2].wa[0], log1[2].wb[0]}), 3'b101);
        check_val("n2_done_c3", int'(log1[3].done), 1);

        // N=256 runs: random idle gaps, random stray starts while busy
        for (int run = 0; run < 2; run++) begin
            gap = int'($urandom_range(1, 20));
            for (int i = 0; i < gap; i++) begin
                check_obs("n256_idle", i, obs8, '0);
                tick();
            end
            foreach (seen[s, a]) seen[s][a] = 0;
            lat    = -1;
            wcount = 0;
            for (int r = 0; r <= 1200 && lat < 0; r++) begin
                check_obs("n256_run", r, obs8, model(8, 3, r));
                if (obs8.wr_en) begin
                    wcount++;
                    if (obs8.stage < 4'd8) begin
                        seen[obs8.stage][obs8.wa[7:0]]++;
                        seen[obs8.stage][obs8.wb[7:0]]++;
                    end
                end
                if (obs8.done) lat = r;
                start8 = (r == 0) || (r <= 1049 && $urandom_range(0, 15) == 0);
                tick();
            end
            start8 = 1'b0;
            bad = 0;
            for (int s = 0; s < 8; s++) begin
                for (int a = 0; a < 256; a++) begin
                    if (seen[s][a] != 1) bad++;
                end
            end
            check_val("n256_latency", lat, 1049);
            check_val("n256_writes", wcount, 1024);
            check_val("n256_once", bad, 0);
        end
        tick();
        check_obs("n256_final_idle", 0, obs8, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
